// File: rtl/ltc2308_pkg.sv
// Shared constants, FSM encoding and bus helpers for the LTC2308 window averager.
package ltc2308_pkg;

  localparam int ADC_W  = 12;
  localparam int MAX_CH = 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic [ADC_W-1:0] ch_slice(input logic [MAX_CH*ADC_W-1:0] bus,
                                                input logic [2:0]              k);
    return bus[k*ADC_W +: ADC_W];
  endfunction

endpackage

// File: rtl/ltc2308_avg_if.sv
// Sample-bus and statistics-output bundle between the ADC controller side and consumers.
interface ltc2308_avg_if #(parameter int NUM_CH = 2);

  logic [NUM_CH*12-1:0] adc_dout;
  logic                 adc_sync;
  logic                 overrun_clr;
  logic [NUM_CH*12-1:0] avg;
  logic [NUM_CH*12-1:0] avg_min;
  logic [NUM_CH*12-1:0] avg_max;
  logic                 avg_valid;
  logic                 avg_sync;
  logic                 overrun;

  modport master (output adc_dout, adc_sync, overrun_clr,
                  input  avg, avg_min, avg_max, avg_valid, avg_sync, overrun);

  modport slave  (input  adc_dout, adc_sync, overrun_clr,
                  output avg, avg_min, avg_max, avg_valid, avg_sync, overrun);

endinterface

// File: rtl/ltc2308_ch_stats.sv
// Per-channel accumulator/min/max storage; one channel is updated per cycle.
module ltc2308_ch_stats
  import ltc2308_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int AVG_LOG2 = 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ACC_W    = ADC_W + AVG_LOG2
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    first,
  input  logic [CH_W-1:0]         ch,
  input  logic [ADC_W-1:0]        sample,
  output logic [NUM_CH*ADC_W-1:0] mean_all,
  output logic [NUM_CH*ADC_W-1:0] min_all,
  output logic [NUM_CH*ADC_W-1:0] max_all
);

  // Half an LSB of the final shift, so the truncating shift rounds half-up.
  localparam logic [ACC_W-1:0] RND = ACC_W'((2**AVG_LOG2) / 2);

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ADC_W-1:0] mn_q  [NUM_CH];
  logic [ADC_W-1:0] mx_q  [NUM_CH];

  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] acc_nx;
  logic [ADC_W-1:0] mn_nx;
  logic [ADC_W-1:0] mx_nx;

  assign sample_ext = ACC_W'(sample);
  assign acc_nx     = first ? sample_ext + RND : acc_q[ch] + sample_ext;
  assign mn_nx      = (first || sample < mn_q[ch]) ? sample : mn_q[ch];
  assign mx_nx      = (first || sample > mx_q[ch]) ? sample : mx_q[ch];

  always_ff @(posedge clk) begin
    if (en) begin
      acc_q[ch] <= acc_nx;
      mn_q[ch]  <= mn_nx;
      mx_q[ch]  <= mx_nx;
    end
  end

  // The channel being processed this cycle is seen with its updated value.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             hit;
    logic [ACC_W-1:0] acc_k;

    assign hit   = en && (ch == CH_W'(k));
    assign acc_k = hit ? acc_nx : acc_q[k];
    assign mean_all[k*ADC_W +: ADC_W] = acc_k[ACC_W-1:AVG_LOG2];
    assign min_all[k*ADC_W +: ADC_W]  = hit ? mn_nx : mn_q[k];
    assign max_all[k*ADC_W +: ADC_W]  = hit ? mx_nx : mx_q[k];
  end

endmodule

// File: rtl/ltc2308_avg.sv
// Windowed mean/min/max of LTC2308 rounds, one channel processed per cycle after each round toggle.
//   state | meaning
//   IDLE  | waiting for an adc_sync toggle; a toggle snapshots the sample bus
//   ACCUM | folding snapshot channel ch into the window statistics
module ltc2308_avg
  import ltc2308_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int AVG_LOG2 = 4
) (
  input logic          clk,
  input logic          reset,
  ltc2308_avg_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RC_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  state_t                  state, state_nx;
  logic                    prev_sync, sync_evt;
  logic                    snap_ld, proc, last_ch, first, win_end;
  logic [CH_W-1:0]         ch;
  logic [RC_W-1:0]         rcnt;
  logic [NUM_CH*ADC_W-1:0] snap;
  logic [MAX_CH*ADC_W-1:0] snap_pad;
  logic [ADC_W-1:0]        sample;
  logic [NUM_CH*ADC_W-1:0] mean_all, min_all, max_all;
  logic [NUM_CH*ADC_W-1:0] avg_q, min_q, max_q;
  logic                    valid_q, sync_q, overrun_q;

  assign sync_evt = bus.adc_sync ^ prev_sync;
  assign last_ch  = (ch == CH_W'(NUM_CH - 1));
  assign first    = (rcnt == '0);
  assign win_end  = proc && last_ch && (rcnt == RC_W'(2**AVG_LOG2 - 1));

  always_comb begin
    snap_pad                     = '0;
    snap_pad[NUM_CH*ADC_W-1:0]   = snap;
  end

  assign sample = ch_slice(snap_pad, 3'(ch));

  always_comb begin
    state_nx = state;
    snap_ld  = 1'b0;
    proc     = 1'b0;
    case (state)
      IDLE: begin
        if (sync_evt) begin
          snap_ld  = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        proc = 1'b1;
        if (last_ch) state_nx = IDLE;
      end
    endcase
  end

  // Tracks the upstream toggle even in reset so a stale level never looks like an event.
  always_ff @(posedge clk) prev_sync <= bus.adc_sync;

  always_ff @(posedge clk) begin
    if (snap_ld) snap <= bus.adc_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= '0;
      rcnt      <= '0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_q <= win_end;
      if (snap_ld)   ch <= '0;
      else if (proc) ch <= ch + 1'b1;
      if (proc && last_ch) rcnt <= win_end ? '0 : rcnt + 1'b1;
      if (win_end) begin
        avg_q  <= mean_all;
        min_q  <= min_all;
        max_q  <= max_all;
        sync_q <= ~sync_q;
      end
      if (sync_evt && state == ACCUM) overrun_q <= 1'b1;
      else if (bus.overrun_clr)       overrun_q <= 1'b0;
    end
  end

  ltc2308_ch_stats #(.NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2)) u_stats (
    .clk      (clk),
    .en       (proc),
    .first    (first),
    .ch       (ch),
    .sample   (sample),
    .mean_all (mean_all),
    .min_all  (min_all),
    .max_all  (max_all)
  );

  assign bus.avg       = avg_q;
  assign bus.avg_min   = min_q;
  assign bus.avg_max   = max_q;
  assign bus.avg_valid = valid_q;
  assign bus.avg_sync  = sync_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ltc2308_avg.sv
// Bench for ltc2308_avg: instance 0 is 2 channels / 4-round windows, instance 1 is 4 channels / pass-through.
module tb_ltc2308_avg;

  logic clk;
  logic reset;

  ltc2308_avg_if #(.NUM_CH(2)) ifa ();
  ltc2308_avg_if #(.NUM_CH(4)) ifb ();

  ltc2308_avg #(.NUM_CH(2), .AVG_LOG2(2)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  ltc2308_avg #(.NUM_CH(4), .AVG_LOG2(0)) u_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: raw rounds of the current window, and the expected published results.
  int         hist [2][4][4];
  int         hcnt [2];
  logic [11:0] e_avg [2][4];
  logic [11:0] e_min [2][4];
  logic [11:0] e_max [2][4];
  logic        e_sync [2];
  logic        e_ovr  [2];

  function automatic int nch(input int inst);
    return (inst == 0) ? 2 : 4;
  endfunction

  function automatic int lg2(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] get_bus(input int inst, input int which);
    logic [47:0] r;
    r = '0;
    if (inst == 0) begin
      case (which)
        0:       r = 48'(ifa.avg);
        1:       r = 48'(ifa.avg_min);
        default: r = 48'(ifa.avg_max);
      endcase
    end else begin
      case (which)
        0:       r = ifb.avg;
        1:       r = ifb.avg_min;
        default: r = ifb.avg_max;
      endcase
    end
    return r;
  endfunction

  function automatic logic get_bit(input int inst, input int which);
    logic r;
    if (inst == 0) r = (which == 0) ? ifa.avg_valid : (which == 1) ? ifa.avg_sync : ifa.overrun;
    else           r = (which == 0) ? ifb.avg_valid : (which == 1) ? ifb.avg_sync : ifb.overrun;
    return r;
  endfunction

  function automatic logic [47:0] rand_smp();
    logic [47:0] r;
    for (int c = 0; c < 4; c++) r[c*12 +: 12] = 12'($urandom_range(0, 4095));
    return r;
  endfunction

  task automatic check_outputs(input int inst, input string where);
    logic [47:0] a, mn, mx;
    a  = get_bus(inst, 0);
    mn = get_bus(inst, 1);
    mx = get_bus(inst, 2);
    for (int c = 0; c < nch(inst); c++) begin
      chk($sformatf("%s_i%0d_avg_ch%0d", where, inst, c), 48'(a[c*12 +: 12]),  48'(e_avg[inst][c]));
      chk($sformatf("%s_i%0d_min_ch%0d", where, inst, c), 48'(mn[c*12 +: 12]), 48'(e_min[inst][c]));
      chk($sformatf("%s_i%0d_max_ch%0d", where, inst, c), 48'(mx[c*12 +: 12]), 48'(e_max[inst][c]));
    end
    chk($sformatf("%s_i%0d_avg_sync", where, inst), 48'(get_bit(inst, 1)), 48'(e_sync[inst]));
    chk($sformatf("%s_i%0d_overrun", where, inst),  48'(get_bit(inst, 2)), 48'(e_ovr[inst]));
  endtask

  // Toggle adc_sync with new data; an accepted round is folded into the model.
  task automatic fire(input int inst, input logic [47:0] smp, input bit accept, output bit win);
    int w, sum, mn, mx, s;
    win = 1'b0;
    if (inst == 0) begin
      ifa.adc_dout = smp[23:0];
      ifa.adc_sync = ~ifa.adc_sync;
    end else begin
      ifb.adc_dout = smp;
      ifb.adc_sync = ~ifb.adc_sync;
    end
    if (accept) begin
      w = 1 << lg2(inst);
      for (int c = 0; c < nch(inst); c++) hist[inst][c][hcnt[inst]] = int'(smp[c*12 +: 12]);
      hcnt[inst]++;
      if (hcnt[inst] == w) begin
        win = 1'b1;
        for (int c = 0; c < nch(inst); c++) begin
          sum = 0; mn = 4095; mx = 0;
          for (int r = 0; r < w; r++) begin
            s = hist[inst][c][r];
            sum += s;
            if (s < mn) mn = s;
            if (s > mx) mx = s;
          end
          e_avg[inst][c] = 12'((sum + w / 2) / w);
          e_min[inst][c] = 12'(mn);
          e_max[inst][c] = 12'(mx);
        end
        e_sync[inst] = ~e_sync[inst];
        hcnt[inst]   = 0;
      end
    end
  endtask

  task automatic round(input int inst, input logic [47:0] smp, input int gap);
    bit win;
    int pulses;
    pulses = 0;
    fire(inst, smp, 1'b1, win);
    for (int i = 1; i <= gap; i++) begin
      step();
      if (get_bit(inst, 0)) pulses++;
      if (i == nch(inst) + 1) begin
        chk($sformatf("i%0d_valid_at_latency", inst), 48'(get_bit(inst, 0)), 48'(win));
        if (win) check_outputs(inst, "win");
      end
    end
    chk($sformatf("i%0d_valid_pulse_count", inst), 48'(pulses), 48'(win));
    check_outputs(inst, "hold");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hcnt[i] = 0; e_sync[i] = 1'b0; e_ovr[i] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        e_avg[i][c] = '0; e_min[i][c] = '0; e_max[i][c] = '0;
      end
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_i%0d_valid", i), 48'(get_bit(i, 0)), 48'(0));
      check_outputs(i, "rst");
    end
    reset = 1'b0;
  endtask

  initial begin
    bit          dummy;
    logic [47:0] smp;
    int          pulses;

    reset           = 1'b1;
    ifa.adc_dout    = '0; ifa.adc_sync = 1'b1; ifa.overrun_clr = 1'b0;
    ifb.adc_dout    = '0; ifb.adc_sync = 1'b1; ifb.overrun_clr = 1'b0;
    do_reset();

    // adc_sync held high through reset: release must not create an event.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ifa.avg_valid || ifb.avg_valid) pulses++;
    end
    chk("no_event_after_reset", 48'(pulses), 48'(0));

    // Constant channels, widely spaced toggles.
    for (int r = 0; r < 4; r++) round(0, {24'd0, 12'd4095, 12'd100}, 2000);

    // Half-up rounding cases on ch0, random ch1, at minimum spacing.
    round(0, {24'd0, 12'($urandom_range(0, 4095)), 12'd1}, 3);
    for (int r = 0; r < 3; r++) round(0, {24'd0, 12'($urandom_range(0, 4095)), 12'd2}, 3);
    for (int r = 0; r < 3; r++) round(0, {24'd0, 12'($urandom_range(0, 4095)), 12'd1}, 3);
    round(0, {24'd0, 12'($urandom_range(0, 4095)), 12'd2}, 3);

    // Random windows with random legal spacing.
    for (int r = 0; r < 12; r++) round(0, rand_smp(), $urandom_range(3, 12));

    // Pass-through instance at minimum spacing.
    for (int r = 0; r < 6; r++) round(1, rand_smp(), 5);

    // Toggle two cycles into processing: dropped, overrun set, first round still published.
    fire(1, rand_smp(), 1'b1, dummy);
    step(); step();
    fire(1, rand_smp(), 1'b0, dummy);
    e_ovr[1] = 1'b1;
    step();
    chk("overrun_set", 48'(ifb.overrun), 48'(1));
    step(); step();
    chk("overrun_first_valid", 48'(ifb.avg_valid), 48'(1));
    check_outputs(1, "ovr");
    repeat (4) step();
    chk("overrun_sticky", 48'(ifb.overrun), 48'(1));
    ifb.overrun_clr = 1'b1;
    step();
    ifb.overrun_clr = 1'b0;
    e_ovr[1] = 1'b0;
    chk("overrun_cleared", 48'(ifb.overrun), 48'(0));

    // Clear coincident with a new overrun: set wins.
    fire(1, rand_smp(), 1'b1, dummy);
    step(); step();
    fire(1, rand_smp(), 1'b0, dummy);
    ifb.overrun_clr = 1'b1;
    e_ovr[1] = 1'b1;
    step();
    ifb.overrun_clr = 1'b0;
    chk("overrun_set_wins", 48'(ifb.overrun), 48'(1));
    step(); step();
    chk("overrun2_first_valid", 48'(ifb.avg_valid), 48'(1));
    check_outputs(1, "ovr2");
    repeat (4) step();
    round(1, rand_smp(), 6);

    // Reset after two of four rounds: partial window discarded.
    round(0, {24'd0, 12'd4000, 12'd10}, 6);
    round(0, {24'd0, 12'd4000, 12'd10}, 6);
    do_reset();
    repeat (3) step();
    for (int r = 0; r < 4; r++) round(0, {24'd0, 12'd500, 12'd500}, 5);
    smp = get_bus(0, 1);
    chk("post_reset_min_ch0", 48'(smp[11:0]), 48'(500));
    smp = get_bus(0, 2);
    chk("post_reset_max_ch1", 48'(smp[23:12]), 48'(500));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
